// File: rtl/hvac_thermostat_cmd.sv
// Thermostat command initiator for HVAC_Control.
// Turns temperature samples into heat/cool demand with a hysteresis band.
// Issues single-cycle command pulses and checks each one against the
// controller's status lines. Enforces a minimum dwell in HEAT/COOL and
// latches a sticky fault when an acknowledge never arrives.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_OFF       | system off, waiting for enable
// S_WAIT_ON   | cmd_on issued, waiting for stat_on
// S_IDLE_ON   | system on, no heating or cooling, acting on demand
// S_WAIT_HEAT | cmd_heat issued, waiting for stat_heat
// S_HEAT      | heating; serving minimum dwell before any change
// S_WAIT_COOL | cmd_cool issued, waiting for stat_cool
// S_COOL      | cooling; serving minimum dwell before any change
// S_WAIT_OFF  | cmd_off issued, waiting for stat_off
// S_FAULT     | acknowledge timed out; one cmd_off, then silent until reset
module hvac_thermostat_cmd #(
  parameter int TEMP_W      = 8,
  parameter int HYST        = 2,
  parameter int MIN_DWELL   = 16,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [TEMP_W-1:0] temp,
  input  logic [TEMP_W-1:0] setpoint,
  input  logic              sample_valid,
  input  logic              stat_on,
  input  logic              stat_heat,
  input  logic              stat_cool,
  input  logic              stat_off,
  output logic              cmd_on,
  output logic              cmd_heat,
  output logic              cmd_cool,
  output logic              cmd_off,
  output logic [1:0]        mode,
  output logic              busy,
  output logic              fault
);

  // Thresholds use one extra bit so setpoint +/- HYST can be saturated.
  localparam int TW  = TEMP_W + 1;
  localparam int DW  = $clog2(MIN_DWELL + 1);
  localparam int TOW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [TW-1:0]  HYST_X    = TW'(HYST);
  localparam logic [TW-1:0]  TEMP_MAX  = {1'b0, {TEMP_W{1'b1}}};
  localparam logic [DW-1:0]  DWELL_MAX = DW'(MIN_DWELL);
  // Last counter value at which a missing acknowledge is still tolerated.
  localparam logic [TOW-1:0] TO_LAST   = TOW'(ACK_TIMEOUT - 1);

  localparam logic [1:0] MODE_OFF  = 2'd0;
  localparam logic [1:0] MODE_IDLE = 2'd1;
  localparam logic [1:0] MODE_HEAT = 2'd2;
  localparam logic [1:0] MODE_COOL = 2'd3;

  // Command vector ordering: {on, heat, cool, off}.
  localparam logic [3:0] CMD_NONE = 4'b0000;
  localparam logic [3:0] CMD_ON   = 4'b1000;
  localparam logic [3:0] CMD_HEAT = 4'b0100;
  localparam logic [3:0] CMD_COOL = 4'b0010;
  localparam logic [3:0] CMD_OFF  = 4'b0001;

  typedef enum logic [3:0] {
    S_OFF,
    S_WAIT_ON,
    S_IDLE_ON,
    S_WAIT_HEAT,
    S_HEAT,
    S_WAIT_COOL,
    S_COOL,
    S_WAIT_OFF,
    S_FAULT
  } state_t;

  typedef enum logic [1:0] {
    DEM_NONE,
    DEM_HEAT,
    DEM_COOL
  } demand_t;

  state_t         state, state_nxt;
  demand_t        demand;
  logic [3:0]     cmd_q, cmd_nxt;
  logic [1:0]     mode_q, mode_nxt;
  logic [DW-1:0]  dwell, dwell_nxt;
  logic [TOW-1:0] tcnt, tcnt_nxt;
  logic           off_sent, off_sent_nxt;

  logic [TW-1:0]  sp_x, temp_x, lo_x, hi_sum, hi_x;
  logic           dwell_done;
  logic           pulse_live;
  logic           ack_hit;
  state_t         ack_state;
  logic [1:0]     ack_mode;

  assign sp_x   = {1'b0, setpoint};
  assign temp_x = {1'b0, temp};
  assign lo_x   = (sp_x >= HYST_X) ? (sp_x - HYST_X) : '0;
  assign hi_sum = sp_x + HYST_X;
  assign hi_x   = (hi_sum > TEMP_MAX) ? TEMP_MAX : hi_sum;

  assign dwell_done = (dwell == DWELL_MAX);
  // The first WAIT cycle carries the pulse; the timeout count starts after it.
  assign pulse_live = |cmd_q;

  // Demand register: updated on samples, hysteresis holds it inside the band.
  always_ff @(posedge clk) begin
    if (reset) begin
      demand <= DEM_NONE;
    end else if (!enable) begin
      demand <= DEM_NONE;
    end else if (sample_valid) begin
      if (temp_x < lo_x) begin
        demand <= DEM_HEAT;
      end else if (temp_x > hi_x) begin
        demand <= DEM_COOL;
      end
    end
  end

  // Acknowledge decode: which status line closes the current wait, and where to go.
  always_comb begin
    ack_hit   = 1'b0;
    ack_state = S_OFF;
    ack_mode  = MODE_OFF;
    case (state)
      S_WAIT_ON: begin
        ack_hit   = stat_on;
        ack_state = S_IDLE_ON;
        ack_mode  = MODE_IDLE;
      end
      S_WAIT_HEAT: begin
        ack_hit   = stat_heat;
        ack_state = S_HEAT;
        ack_mode  = MODE_HEAT;
      end
      S_WAIT_COOL: begin
        ack_hit   = stat_cool;
        ack_state = S_COOL;
        ack_mode  = MODE_COOL;
      end
      S_WAIT_OFF: begin
        ack_hit   = stat_off;
        ack_state = S_OFF;
        ack_mode  = MODE_OFF;
      end
      default: begin
        ack_hit   = 1'b0;
      end
    endcase
  end

  // Next-state, next-command and counter logic.
  always_comb begin
    state_nxt    = state;
    cmd_nxt      = CMD_NONE;
    mode_nxt     = mode_q;
    dwell_nxt    = dwell;
    tcnt_nxt     = tcnt;
    off_sent_nxt = off_sent;
    case (state)
      S_OFF: begin
        if (enable) begin
          cmd_nxt   = CMD_ON;
          state_nxt = S_WAIT_ON;
          tcnt_nxt  = '0;
        end
      end
      S_WAIT_ON, S_WAIT_HEAT, S_WAIT_COOL, S_WAIT_OFF: begin
        if (ack_hit) begin
          state_nxt = ack_state;
          mode_nxt  = ack_mode;
          dwell_nxt = '0;
        end else if (pulse_live) begin
          tcnt_nxt = '0;
        end else begin
          tcnt_nxt = tcnt + 1'b1;
          if (tcnt == TO_LAST) begin
            state_nxt = S_FAULT;
          end
        end
      end
      S_IDLE_ON: begin
        if (!enable) begin
          cmd_nxt   = CMD_OFF;
          state_nxt = S_WAIT_OFF;
          tcnt_nxt  = '0;
        end else if (demand == DEM_HEAT) begin
          cmd_nxt   = CMD_HEAT;
          state_nxt = S_WAIT_HEAT;
          tcnt_nxt  = '0;
        end else if (demand == DEM_COOL) begin
          cmd_nxt   = CMD_COOL;
          state_nxt = S_WAIT_COOL;
          tcnt_nxt  = '0;
        end
      end
      S_HEAT: begin
        if (!dwell_done) begin
          dwell_nxt = dwell + 1'b1;
        end else if (!enable) begin
          cmd_nxt   = CMD_OFF;
          state_nxt = S_WAIT_OFF;
          tcnt_nxt  = '0;
        end else if (demand == DEM_COOL) begin
          cmd_nxt   = CMD_COOL;
          state_nxt = S_WAIT_COOL;
          tcnt_nxt  = '0;
        end
      end
      S_COOL: begin
        if (!dwell_done) begin
          dwell_nxt = dwell + 1'b1;
        end else if (!enable) begin
          cmd_nxt   = CMD_OFF;
          state_nxt = S_WAIT_OFF;
          tcnt_nxt  = '0;
        end else if (demand == DEM_HEAT) begin
          cmd_nxt   = CMD_HEAT;
          state_nxt = S_WAIT_HEAT;
          tcnt_nxt  = '0;
        end
      end
      S_FAULT: begin
        // A single best-effort off command; after that the block stays silent.
        if (!off_sent) begin
          cmd_nxt      = CMD_OFF;
          off_sent_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = S_OFF;
      end
    endcase
  end

  // State, command, mode and counter registers; reset drops any in-flight pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_OFF;
      cmd_q    <= CMD_NONE;
      mode_q   <= MODE_OFF;
      dwell    <= '0;
      tcnt     <= '0;
      off_sent <= 1'b0;
    end else begin
      state    <= state_nxt;
      cmd_q    <= cmd_nxt;
      mode_q   <= mode_nxt;
      dwell    <= dwell_nxt;
      tcnt     <= tcnt_nxt;
      off_sent <= off_sent_nxt;
    end
  end

  assign cmd_on   = cmd_q[3];
  assign cmd_heat = cmd_q[2];
  assign cmd_cool = cmd_q[1];
  assign cmd_off  = cmd_q[0];
  assign mode     = mode_q;
  assign busy     = (state == S_WAIT_ON) || (state == S_WAIT_HEAT) ||
                    (state == S_WAIT_COOL) || (state == S_WAIT_OFF);
  assign fault    = (state == S_FAULT);

endmodule

// File: doc/hvac_thermostat_cmd.md
Name: hvac_thermostat_cmd

Overview:
- Command-side initiator for the HVAC_Control block.
- Compares a sampled temperature against a setpoint with hysteresis and issues single-cycle command pulses that drive HVAC_Control's I1 (on), I2 (heat), I3 (cool) and I4 (off) inputs.
- Checks each command against HVAC_Control's O1..O4 status lines, enforces a minimum mode dwell time, and latches a fault if a command is not acknowledged.

Parameters:
- TEMP_W, 8, width of the temperature and setpoint values (unsigned)
- HYST, 2, half-width of the dead band, in temperature LSBs
- MIN_DWELL, 16, minimum number of cycles spent in HEAT or COOL before another mode change
- ACK_TIMEOUT, 8, maximum number of cycles to wait for a status acknowledge after a command pulse

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- enable  input  1  1 = thermostat requests the system on; 0 = requests off
- temp  input  TEMP_W  current temperature; valid only when sample_valid=1
- setpoint  input  TEMP_W  target temperature; sampled together with temp
- sample_valid  input  1  single-cycle strobe qualifying temp and setpoint
- stat_on  input  1  from HVAC_Control O1: system on
- stat_heat  input  1  from HVAC_Control O2: heating active
- stat_cool  input  1  from HVAC_Control O3: cooling active
- stat_off  input  1  from HVAC_Control O4: system off
- cmd_on  output  1  to I1; single-cycle pulse
- cmd_heat  output  1  to I2; single-cycle pulse
- cmd_cool  output  1  to I3; single-cycle pulse
- cmd_off  output  1  to I4; single-cycle pulse
- mode  output  2  0=OFF, 1=IDLE_ON, 2=HEAT, 3=COOL (last acknowledged mode)
- busy  output  1  high while waiting for an acknowledge
- fault  output  1  sticky acknowledge-timeout flag

Behaviour:
- Reset:
  - All cmd_* = 0, mode = 0, busy = 0, fault = 0.
  - State = OFF; dwell and timeout counters = 0; demand register = NONE.
- Command outputs:
  - Registered.
  - At most one cmd_* is high in any cycle.
  - Each pulse is exactly one cycle wide.
- Thresholds are computed in TEMP_W+1 bits and saturated:
  - lo = max(setpoint-HYST, 0)
  - hi = min(setpoint+HYST, 2^TEMP_W-1)
- Demand (registered on sample_valid only):
  - temp < lo → HEAT
  - temp > hi → COOL
  - otherwise the previous demand is held (hysteresis)
  - Demand is cleared to NONE while enable=0.
- States: OFF, WAIT_ON, IDLE_ON, WAIT_HEAT, HEAT, WAIT_COOL, COOL, WAIT_OFF, FAULT.
- OFF:
  - enable=1 → pulse cmd_on, go to WAIT_ON.
- WAIT_x (busy=1):
  - Timeout counter starts at 0 in the cycle after the pulse.
  - Matching status seen (stat_on / stat_heat / stat_cool / stat_off) → go to the target state and update mode.
  - Counter reaches ACK_TIMEOUT without the matching status → go to FAULT.
- IDLE_ON:
  - enable=0 → pulse cmd_off, go to WAIT_OFF.
  - Otherwise demand HEAT → pulse cmd_heat, go to WAIT_HEAT.
  - Otherwise demand COOL → pulse cmd_cool, go to WAIT_COOL.
- HEAT / COOL:
  - The dwell counter clears on entry and counts up to MIN_DWELL, then saturates.
  - No transition (including off) is taken until dwell ≥ MIN_DWELL.
  - Once dwell is satisfied:
    - enable=0 → cmd_off → WAIT_OFF (takes priority)
    - else opposite demand → issue the opposite command directly (HEAT→WAIT_COOL, COOL→WAIT_HEAT)
    - demand NONE or the same mode → stay
- WAIT_OFF:
  - stat_off → OFF, mode=0.
- FAULT:
  - fault=1, busy=0.
  - cmd_off is pulsed once, in the cycle after entry.
  - No further commands; exit only by reset.
- Simultaneous events:
  - sample_valid in the same cycle as a transition decision: the decision uses the demand registered before that cycle; the new demand applies from the next cycle.
  - enable and sample_valid toggling while in a WAIT_x state are registered, but no command is issued until the acknowledge arrives.
- Reset mid-operation:
  - Any in-flight pulse is dropped and all counters are cleared.
  - No off command is issued.

Test Plan:
- reset; enable=1; stat_on returned 2 cycles after cmd_on → exactly one cmd_on pulse; busy high for 2 cycles; mode=1.
- IDLE_ON, setpoint=20, sample_valid with temp=17 → cmd_heat; stat_heat acknowledges → mode=2. Then temp=21 → no command (inside band 18..22).
- HEAT after 5 cycles, temp=25 → no command until dwell=16; then cmd_cool one cycle, stat_cool acknowledges → mode=3.
- Boundaries:
  - setpoint=1, temp=0 → lo saturates to 0, no heat demand.
  - setpoint=254, temp=255 → hi saturates to 255, no cool demand.
- WAIT_ON with stat_on held 0 → fault=1 after 8 cycles, then a single cmd_off pulse, then no further pulses; reset clears fault.
- COOL with dwell satisfied, enable=0 while temp=30 → cmd_off (not a heat/cool command); stat_off → mode=0. Reset asserted during WAIT_HEAT → all outputs 0 in the next cycle.
